imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_pkg.sv | 20 ++
 rtl/imem_array.sv | 31 +++
 rtl/imem_responder.sv | 126 ++++++++++++
 tb/tb_imem_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared defines for the instruction-memory responder.
//   RegWidth : architectural register / PC width
//   PcRst    : reset PC, byte address of instruction word 0
//   NOP      : instruction returned on a faulted fetch (addi x0,x0,0)
//   CNT_W    : latency counter width (holds LATENCY-1 for LATENCY up to 15)
//   state_t  : responder FSM encoding
package imem_responder_pkg;

  localparam int                    RegWidth = 64;
  localparam logic [RegWidth-1:0]   PcRst    = 64'h0000_0000_8000_0000;
  localparam logic [31:0]           NOP      = 32'h0000_0013;
  localparam int                    CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one asynchronous
// read port.
//   clk     : clock, write on rising edge
//   wr_en   : write strobe
//   wr_idx  : word index written
//   wr_data : word written
//   rd_idx  : word index read (combinational)
//   rd_data : word at rd_idx; a same-edge write is seen only after that edge
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset; its contents are the loaded image
  // and must survive rst, and a reset would also block RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, answers after a
// fixed latency from the image held in imem_array.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake, req_addr is the byte PC
//   rsp_valid/rsp_ready  : response handshake, rsp_inst/rsp_err the result
//   ld_en/ld_idx/ld_data : image-load write port, usable in any state
// Build option: define IMEM_MISALIGN_CHECK_EN to fault fetches whose
// req_addr[1:0] is non-zero; otherwise the low bits are ignored.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                ADDR_W  = RegWidth,
  parameter int                DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(PcRst),
  parameter int                LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        inst_q;
  logic               err_q;
  logic               load_rsp;

  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  word_idx;
  logic [31:0]        rd_data;
  logic               out_of_range;
  logic               misaligned;
  logic               fetch_err;
  logic [31:0]        fetch_inst;

  // With LATENCY=1 the response is captured on the acceptance edge itself,
  // before addr_q holds the new address, so the read uses req_addr in IDLE.
  assign rd_addr  = (state_q == IDLE) ? req_addr : addr_q;
  // Full-width subtract: an address below BASE wraps to a huge index.
  assign word_idx = (rd_addr - BASE) >> 2;
  assign out_of_range = (word_idx >= ADDR_W'(DEPTH));

`ifdef IMEM_MISALIGN_CHECK_EN
  assign misaligned = (rd_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign fetch_err  = out_of_range | misaligned;
  assign fetch_inst = fetch_err ? NOP : rd_data;

  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_idx  (word_idx[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // NOTE: every output and next-state variable gets a default before the
  // case so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_inst  = rsp_valid ? inst_q : 32'h0;
    rsp_err   = rsp_valid & err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The response word is sampled exactly once, on the edge entering RESP;
    // a load on that same edge is not yet visible (read-before-write).
    load_rsp = (state_d == RESP) && (state_q != RESP);
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_valid && req_ready) addr_q <= req_addr;
      if (load_rsp) begin
        inst_q <= fetch_inst;
        err_q  <= fetch_err;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder. The main instance uses
// LATENCY=2; two extra instances (LATENCY=1 and LATENCY=4) share its inputs
// and are examined in the back-to-back scenario.
module tb_imem_responder;
  import imem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic        rsp_ready = 1'b0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_inst;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_inst1;
  logic        req_ready4, rsp_valid4, rsp_err4;
  logic [31:0] rsp_inst4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst), .rsp_err(rsp_err), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_data(ld_data)
  );

  imem_responder #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_addr(req_addr), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst1), .rsp_err(rsp_err1), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_data(ld_data)
  );

  imem_responder #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_addr(req_addr), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst4), .rsp_err(rsp_err4), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_data(ld_data)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_idx  = idx[9:0];
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !req_ready; i++) tick();
  endtask

  // Issues one request; lat = cycles from acceptance to rsp_valid, -1 if none.
  task automatic do_req(input logic [63:0] addr, output int lat);
    int n;
    wait_idle();
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    lat = rsp_valid ? n : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++;
    if (rsp_inst !== 32'h0) begin bad++; $display("FAIL reset_rsp_inst: got %h want 0", rsp_inst); end
    total++;
    if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
  endtask

  task automatic test_basic();
    int lat;
    load(0, 32'h0010_0093);
    load(1, 32'h0020_0113);
    rsp_ready = 1'b1;
    do_req(64'h8000_0000, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
    total++;
    if (rsp_inst !== 32'h0010_0093) begin bad++; $display("FAIL basic_inst: got %h want 00100093", rsp_inst); end
    total++;
    if (rsp_err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", rsp_err); end
    tick();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL basic_after_hs: ready=%b valid=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    rsp_ready = 1'b0;
    do_req(64'h8000_0004, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL bp_latency: got %0d want 2", lat); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0020_0113 || rsp_err !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: valid=%b inst=%h err=%b want 1/00200113/0", i, rsp_valid, rsp_inst, rsp_err);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_range();
    int lat;
    logic [63:0] addrs [3];
    logic [31:0] want_inst [3];
    logic        want_err [3];
    load(1023, 32'hCAFE_F00D);
    addrs[0] = 64'h8000_1000; want_inst[0] = 32'h0000_0013; want_err[0] = 1'b1;
    addrs[1] = 64'h7FFF_FFFC; want_inst[1] = 32'h0000_0013; want_err[1] = 1'b1;
    addrs[2] = 64'h8000_0FFC; want_inst[2] = 32'hCAFE_F00D; want_err[2] = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_req(addrs[i], lat);
      total++;
      if (lat !== 2 || rsp_inst !== want_inst[i] || rsp_err !== want_err[i]) begin
        bad++;
        $display("FAIL range_%h: lat=%0d inst=%h err=%b want 2/%h/%b",
                 addrs[i], lat, rsp_inst, rsp_err, want_inst[i], want_err[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int lat;
    logic [31:0] want_inst;
    logic        want_err;
`ifdef IMEM_MISALIGN_CHECK_EN
    want_inst = 32'h0000_0013;
    want_err  = 1'b1;
`else
    want_inst = 32'h0010_0093;
    want_err  = 1'b0;
`endif
    rsp_ready = 1'b1;
    do_req(64'h8000_0002, lat);
    total++;
    if (lat !== 2 || rsp_inst !== want_inst || rsp_err !== want_err) begin
      bad++; $display("FAIL misalign: lat=%0d inst=%h err=%b want 2/%h/%b", lat, rsp_inst, rsp_err, want_inst, want_err);
    end
  endtask

  // A load to the word being fetched on the edge that enters RESP must not
  // reach that response; the following fetch sees the new word.
  task automatic test_read_before_write();
    int lat;
    load(2, 32'h1111_1111);
    rsp_ready = 1'b0;
    wait_idle();
    req_valid = 1'b1;
    req_addr  = 64'h8000_0008;
    tick();
    req_valid = 1'b0;
    ld_en   = 1'b1;
    ld_idx  = 10'd2;
    ld_data = 32'h2222_2222;
    tick();
    ld_en = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_inst !== 32'h1111_1111) begin
      bad++; $display("FAIL rbw_old: valid=%b inst=%h want 1/11111111", rsp_valid, rsp_inst);
    end
    rsp_ready = 1'b1;
    tick();
    do_req(64'h8000_0008, lat);
    total++;
    if (rsp_inst !== 32'h2222_2222) begin bad++; $display("FAIL rbw_new: got %h want 22222222", rsp_inst); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    rsp_ready = 1'b1;
    wait_idle();
    req_valid = 1'b1;
    req_addr  = 64'h8000_0000;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rstmid_no_rsp: got %0d valid cycles want 0", seen); end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
    do_req(64'h8000_0004, lat);
    total++;
    if (lat !== 2 || rsp_inst !== 32'h0020_0113 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_image: lat=%0d inst=%h err=%b want 2/00200113/0", lat, rsp_inst, rsp_err);
    end
  endtask

  task automatic test_back_to_back();
    int lats [3];
    int acc [3];
    int rsp [3];
    int last [3];
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [31:0] inst [3];
    lats[0] = 1; lats[1] = 2; lats[2] = 4;
    for (int k = 0; k < 3; k++) begin acc[k] = 0; rsp[k] = 0; last[k] = -1; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_addr  = 64'h8000_0004;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 60) req_valid = 1'b0;
      rdy = {req_ready4, req_ready, req_ready1};
      vld = {rsp_valid4, rsp_valid, rsp_valid1};
      inst[0] = rsp_inst1; inst[1] = rsp_inst; inst[2] = rsp_inst4;
      for (int k = 0; k < 3; k++) begin
        if (rdy[k] && req_valid) acc[k]++;
        if (vld[k]) begin
          rsp[k]++;
          total++;
          if (last[k] < 0 ? (cyc !== lats[k]) : (cyc - last[k] !== lats[k] + 1)) begin
            bad++; $display("FAIL b2b_spacing_L%0d: rsp at cycle %0d prev %0d want gap %0d", lats[k], cyc, last[k], lats[k] + 1);
          end
          total++;
          if (inst[k] !== 32'h0020_0113) begin
            bad++; $display("FAIL b2b_inst_L%0d: got %h want 00200113", lats[k], inst[k]);
          end
          last[k] = cyc;
        end
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rsp[k] !== acc[k] || rsp[k] < 5) begin
        bad++; $display("FAIL b2b_count_L%0d: responses=%0d acceptances=%0d", lats[k], rsp[k], acc[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_range();
    test_misalign();
    test_read_before_write();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
